// File: rtl/mul32_seq.sv
// mul32_seq: sequential 32x32->64 multiply unit that time-shares one signed 18x18
// combinational multiplier over four cycles, with valid/ready on both sides.
module mul32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_signed,
    input  logic        b_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [17:0] mul_a,
    output logic [17:0] mul_b,
    input  logic [35:0] mul_p
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t      state, state_nx;
    logic [1:0]  step;
    logic [31:0] ra, rb;
    logic        sa, sb;
    logic [63:0] acc, addend;
    logic [17:0] al, ah, bl, bh;
    logic [5:0]  sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (flush)                               state_nx = IDLE;
        else if (state == IDLE && in_valid)      state_nx = MUL;
        else if (state == MUL && step == 2'd3)   state_nx = DONE;
        else if (state == DONE && out_ready)     state_nx = IDLE;
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign result    = acc;
    // High halves carry the operand sign into the two guard bits of the signed multiplier
    assign al = {2'b00, ra[15:0]};
    assign ah = {{2{sa & ra[31]}}, ra[31:16]};
    assign bl = {2'b00, rb[15:0]};
    assign bh = {{2{sb & rb[31]}}, rb[31:16]};
    assign mul_a  = (state == MUL) ? (step[1] ? ah : al) : '0;
    assign mul_b  = (state == MUL) ? (step[0] ? bh : bl) : '0;
    assign sh     = (step == 2'd3) ? 6'd32 : (step == 2'd0) ? 6'd0 : 6'd16;
    assign addend = {{28{mul_p[35]}}, mul_p} << sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
            acc  <= '0;
            ra   <= '0;
            rb   <= '0;
            sa   <= 1'b0;
            sb   <= 1'b0;
        end else if (!flush) begin
            if (state == IDLE && in_valid) begin
                ra   <= a;
                rb   <= b;
                sa   <= a_signed;
                sb   <= b_signed;
                acc  <= '0;
                step <= '0;
            end else if (state == MUL) begin
                acc  <= acc + addend;
                step <= step + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: table-driven and randomized checks of mul32_seq against an
// arithmetic reference, plus hand-written backpressure, flush and reset sequences.
module tb_mul32_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic        a_signed = 1'b0, b_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic [17:0] mul_a, mul_b;
    logic [35:0] mul_p;
    int          checks = 0, errors = 0;
    logic [17:0] ma [4];
    logic [17:0] mb [4];

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        xs;
        logic        ys;
        logic [63:0] exp;
    } vec_t;

    mul32_seq dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
    );

    assign mul_p = 36'($signed(mul_a)) * 36'($signed(mul_b));
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, y, input logic xs, ys);
        longint ex = xs ? longint'($signed(x)) : longint'({32'b0, x});
        longint ey = ys ? longint'($signed(y)) : longint'({32'b0, y});
        return 64'(ex * ey);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [31:0] x, y, input logic xs, ys, input logic [63:0] exp,
                         input string nm);
        @(negedge clk);
        a = x; b = y; a_signed = xs; b_signed = ys; in_valid = 1'b1; out_ready = 1'b0;
        chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        for (int i = 0; i < 4; i++) begin
            ma[i] = mul_a;
            mb[i] = mul_b;
            if (i > 0) chk({nm, " early out_valid"}, 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        chk({nm, " out_valid latency"}, 64'(out_valid), 64'd1);
        chk({nm, " result"}, result, exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " back to idle"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    initial begin
        vec_t        tbl [6];
        logic [63:0] held;
        logic        ok;
        tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001};
        tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001};
        tbl[2] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000};
        tbl[3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFE00000002};
        tbl[4] = '{32'h00000007, 32'h00000006, 1'b0, 1'b0, 64'h000000000000002A};
        tbl[5] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 64'h0B00EA4E242D2080};

        #12;
        chk("reset outputs", {out_valid, in_ready, mul_a, mul_b, 26'd0}, {1'b0, 1'b1, 62'd0});
        chk("reset result", result, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].x, tbl[i].y, tbl[i].xs, tbl[i].ys, tbl[i].exp, $sformatf("vec%0d", i));
            if (i == 0)
                for (int s = 0; s < 4; s++)
                    chk($sformatf("unsigned step%0d operands", s), {28'd0, ma[s], mb[s]},
                        {28'd0, 18'h0FFFF, 18'h0FFFF});
            if (i == 1)
                chk("signed step3 operands", {28'd0, ma[3], mb[3]}, {28'd0, 18'h3FFFF, 18'h3FFFF});
        end

        for (int i = 0; i < 20; i++) begin
            logic [31:0] x, y;
            logic        xs, ys;
            x = $urandom; y = $urandom; xs = 1'($urandom); ys = 1'($urandom);
            if (i < 4) x = {i[0], 31'($urandom_range(0, 3))};
            do_op(x, y, xs, ys, ref_mul(x, y, xs, ys), $sformatf("rand%0d", i));
        end

        // Backpressure: result held for 10 cycles while new requests are offered
        @(negedge clk);
        a = 32'h00010003; b = 32'hFFFF0005; a_signed = 1'b1; b_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        held = ref_mul(32'h00010003, 32'hFFFF0005, 1'b1, 1'b1);
        chk("bp first result", result, held);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        end
        chk("bp stable 10 cycles", 64'(ok), 64'd1);
        @(negedge clk);
        a = 32'd3; b = 32'd5; a_signed = 1'b0; b_signed = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release idle", 64'({in_ready, out_valid}), 64'b10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp next accepted", 64'(in_ready), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("bp next result", result, 64'd15);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;

        // Flush during step 2
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h0BADF00D; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush idle", 64'({in_ready, out_valid}), 64'b10);
        ok = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk("flush no out_valid", 64'(ok), 64'd1);
        do_op(32'd3, 32'd5, 1'b0, 1'b0, 64'd15, "after flush");

        // Flush coinciding with a request in IDLE
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush+valid not taken", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("flush+valid no result", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-MUL
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("reset mid-MUL outputs", {out_valid, in_ready, mul_a, mul_b, 26'd0}, {1'b0, 1'b1, 62'd0});
        chk("reset mid-MUL result", result, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Asynchronous reset mid-DONE
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre-reset DONE", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset mid-DONE outputs", {out_valid, in_ready, mul_a, mul_b, 26'd0}, {1'b0, 1'b1, 62'd0});
        chk("reset mid-DONE result", result, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        do_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 64'h0B00EA4E242D2080, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul32_seq.md
# mul32_seq

Sequential 32x32 to 64-bit multiply unit that time-multiplexes a single zero-latency signed 18x18 DSP multiplier over four cycles. It sits between the CPU execute stage and the multiplier: it splits operands into 16-bit halves, drives the multiplier inputs, and accumulates the four partial products it returns. Operands and results move over valid/ready handshakes.

## Interface
Parameters: none. Widths are fixed by the 18x18 multiplier.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- flush  in  1  synchronous abort; drops any operation in flight
- in_valid  in  1  operand request valid
- in_ready  out  1  unit can accept a request
- a  in  32  multiplicand
- b  in  32  multiplier
- a_signed  in  1  treat a as two's complement
- b_signed  in  1  treat b as two's complement
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  64  full product; a two's-complement value if either operand is signed
- mul_a  out  18  to multiplier A; the multiplier treats it as signed
- mul_b  out  18  to multiplier B; the multiplier treats it as signed
- mul_p  in  36  multiplier product, combinational from mul_a/mul_b in the same cycle

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - MUL: four steps, 2-bit counter `step`.
  - DONE: out_valid=1.
- IDLE→MUL on in_valid&&in_ready. At that edge:
  - capture a, b, a_signed, b_signed into operand registers;
  - clear `acc` (64-bit) to 0;
  - set step to 0.
- Operand halves, each 18 bits:
  - aL = {2'b00, a[15:0]}.
  - aH = a[31:16], sign-extended when a_signed=1, otherwise zero-extended.
  - bL and bH are formed the same way from b and b_signed.
- Multiplier drive in MUL (combinational from step):
  - step0: aL×bL
  - step1: aL×bH
  - step2: aH×bL
  - step3: aH×bH
- In IDLE and DONE, mul_a=mul_b=0.
- Accumulation, each MUL cycle:
  - acc <= acc + (sext64(mul_p) << sh), with sh = 0, 16, 16, 32 for steps 0–3.
  - Addition is modulo 2^64; carries out of bit 63 are discarded.
- MUL→DONE after the step-3 accumulation. result = acc; result is held stable throughout DONE.
- DONE→IDLE on out_valid&&out_ready.
- While the unit is not in IDLE, in_valid is ignored and a/b may change freely.
- flush=1 forces IDLE at the next edge from any state and drops any pending result. acc is not cleared. flush has priority over every transition, including an acceptance in the same cycle: the request is not taken.
- Reset (rst_n=0), asynchronous, any time, including mid-operation:
  - state=IDLE, step=0, acc=0, operand registers=0.
  - Outputs: in_ready=1, out_valid=0, result=0, mul_a=mul_b=0.

## Timing
- Acceptance at edge k:
  - MUL steps 0–3 occupy cycles k..k+3 (the cycles ending at edges k+1..k+4).
  - out_valid=1 from just after edge k+4.
- Latency: 4 cycles from accept edge to out_valid.
- Initiation interval is at least 6 edges: 1 accept + 4 MUL + 1 DONE handshake. in_ready rises only after the DONE→IDLE edge.
- out_valid/result follow a registered-output discipline: no combinational path from out_ready to result, and none from in_valid to in_ready.
- mul_p is sampled in the same cycle that mul_a/mul_b are driven; the multiplier must be purely combinational.
- Backpressure:
  - out_ready low holds DONE indefinitely; result and out_valid stay stable.
  - out_ready high on the first DONE cycle returns to IDLE at the next edge.

## Test plan
1. Unsigned, a=b=0xFFFFFFFF, a_signed=b_signed=0 → result=0xFFFFFFFE00000001.
   - out_valid rises exactly 4 edges after acceptance.
   - mul_a/mul_b in cycles k..k+3 are 0x0FFFF/0x0FFFF, 0x0FFFF/0x0FFFF, 0x0FFFF/0x0FFFF, 0x0FFFF/0x0FFFF (all halves zero-extended).
2. Signed cases, a_signed=b_signed=1:
   - a=b=0xFFFFFFFF → result=0x0000000000000001; step-3 operands are 0x3FFFF/0x3FFFF.
   - a=b=0x80000000 → result=0x4000000000000000.
3. Mixed signedness, a=0xFFFFFFFE (a_signed=1), b=0xFFFFFFFF (b_signed=0) → result=0xFFFFFFFE00000002.
   - Also a=0x00000007, b=0x00000006, both unsigned → result=0x2A.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and varying a/b.
   - result, out_valid=1 and in_ready=0 all stay stable; no new request is accepted.
   - Raise out_ready: IDLE at the next edge; the next request is accepted one edge later.
5. Abort cases:
   - Assert flush in step 2 → IDLE next edge; out_valid never rises; the following request 3×5 returns 15.
   - Assert flush in the same cycle as in_valid in IDLE → request not taken; in_ready stays 1.
6. Asynchronous reset: drop rst_n mid-MUL and mid-DONE, between clock edges.
   - Outputs clear immediately: out_valid=0, result=0, in_ready=1, mul_a=mul_b=0.
   - After release, a fresh 0x12345678×0x9ABCDEF0 (unsigned) returns 0x0B00EA4E242D2080.
